prog_loader: RTL and testbench

Parametrised program/state loader sitting between an external word stream and the RISC-V core. It holds the core stalled, writes an optional register-file preload and an instruction-memory image, then releases the core. It replaces hierarchical memory preloading and makes core boot a synthesizable, handshaked sequence.

---
 rtl/prog_loader.sv | 182 ++++++++++++++++++
 tb/tb_prog_loader.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Boot loader: holds the core, writes an optional register preload and an IMEM image
// from a valid/ready word stream, then releases the core. PROG_LOADER_CHECKSUM_EN adds a trailer check.
module prog_loader #(
  parameter int XLEN       = 32,
  parameter int IMEM_DEPTH = 64,
  parameter int RF_COUNT   = 32,
  localparam int IA        = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1
) (
  input  logic            clk_in,
  input  logic            rst_n,
  input  logic            start,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [XLEN-1:0] s_data,
  input  logic            s_last,
  output logic            im_we,
  output logic [IA-1:0]   im_addr,
  output logic [XLEN-1:0] im_wdata,
  output logic            rf_we,
  output logic [4:0]      rf_addr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            core_hold,
  output logic            done,
  output logic            error,
  output logic [15:0]     word_count,
  output logic [2:0]      fsm_state
);

  // Stream handshake: a word transfers on a rising edge where s_valid && s_ready;
  // s_ready depends only on the registered state, never on s_valid.
  typedef enum logic [2:0] {IDLE, HDR, REGF, IMEM, CSUM, DONE, ERR} state_t;

  localparam logic [16:0] N_LIMIT = 17'(IMEM_DEPTH);
  localparam logic [6:0]  R_LIMIT = 7'(RF_COUNT - 1);

  state_t          state_q, state_d, end_state;
  logic [15:0]     n_q, n_d, idx_q, idx_d, wc_d;
  logic [5:0]      r_q, r_d;
  logic            accept;
  logic [15:0]     hdr_n;
  logic [5:0]      hdr_r;
  logic            im_we_d, rf_we_d, done_d, error_d;
  logic [IA-1:0]   im_addr_d;
  logic [4:0]      rf_addr_d;
  logic [XLEN-1:0] im_wdata_d, rf_wdata_d;

  assign s_ready   = (state_q == HDR) || (state_q == REGF) || (state_q == IMEM) || (state_q == CSUM);
  assign accept    = s_valid && s_ready;
  assign hdr_n     = s_data[15:0];
  assign hdr_r     = s_data[21:16];
  assign fsm_state = state_q;

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [XLEN-1:0] sum_q, sum_d;
  // With a trailer, the last data word must not be marked last.
  assign end_state = s_last ? ERR : CSUM;
`else
  assign end_state = s_last ? DONE : ERR;
`endif

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    r_d        = r_q;
    idx_d      = idx_q;
    wc_d       = word_count;
    im_we_d    = 1'b0;
    rf_we_d    = 1'b0;
    im_addr_d  = im_addr;
    im_wdata_d = im_wdata;
    rf_addr_d  = rf_addr;
    rf_wdata_d = rf_wdata;
`ifdef PROG_LOADER_CHECKSUM_EN
    sum_d      = sum_q;
`endif
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d = HDR;
          wc_d    = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      HDR: begin
        if (accept) begin
          n_d   = hdr_n;
          r_d   = hdr_r;
          idx_d = '0;
          if (({1'b0, hdr_n} > N_LIMIT) || ({1'b0, hdr_r} > R_LIMIT)) state_d = ERR;
          else if (hdr_r != '0) state_d = s_last ? ERR : REGF;
          else if (hdr_n != '0) state_d = s_last ? ERR : IMEM;
          else state_d = end_state;
        end
      end
      REGF: begin
        if (accept) begin
          rf_we_d    = 1'b1;
          rf_addr_d  = idx_q[4:0] + 5'd1;  // x0 is never written
          rf_wdata_d = s_data;
          idx_d      = idx_q + 16'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
          sum_d      = sum_q + s_data;
`endif
          if (idx_q[5:0] == r_q - 6'd1) begin
            idx_d = '0;
            if (n_q != '0) state_d = s_last ? ERR : IMEM;
            else state_d = end_state;
          end else if (s_last) begin
            state_d = ERR;
          end
        end
      end
      IMEM: begin
        if (accept) begin
          im_we_d    = 1'b1;
          im_addr_d  = idx_q[IA-1:0];
          im_wdata_d = s_data;
          idx_d      = idx_q + 16'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
          sum_d      = sum_q + s_data;
`endif
          if (idx_q == n_q - 16'd1) state_d = end_state;
          else if (s_last) state_d = ERR;
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      CSUM: begin
        if (accept) state_d = (s_last && (s_data == sum_q)) ? DONE : ERR;
      end
`endif
      default: state_d = state_q;
    endcase
    if ((im_we_d || rf_we_d) && (wc_d != 16'hFFFF)) wc_d = wc_d + 16'd1;
    // Status follows the state by one edge so the final strobe retires before the core is released.
    done_d  = (state_q == DONE) && (state_d == DONE);
    error_d = (state_q == ERR) && (state_d == ERR);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      n_q        <= '0;
      r_q        <= '0;
      idx_q      <= '0;
      word_count <= '0;
      im_we      <= 1'b0;
      im_addr    <= '0;
      im_wdata   <= '0;
      rf_we      <= 1'b0;
      rf_addr    <= '0;
      rf_wdata   <= '0;
      done       <= 1'b0;
      error      <= 1'b0;
      core_hold  <= 1'b1;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      r_q        <= r_d;
      idx_q      <= idx_d;
      word_count <= wc_d;
      im_we      <= im_we_d;
      im_addr    <= im_addr_d;
      im_wdata   <= im_wdata_d;
      rf_we      <= rf_we_d;
      rf_addr    <= rf_addr_d;
      rf_wdata   <= rf_wdata_d;
      done       <= done_d;
      error      <= error_d;
      core_hold  <= !done_d;
    end
  end

`ifdef PROG_LOADER_CHECKSUM_EN
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) sum_q <= '0;
    else        sum_q <= sum_d;
  end
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: expected writes go into a queue, a negedge monitor
// pops and compares every strobe; status outputs are checked at fixed offsets.
module tb_prog_loader;
  localparam int XLEN = 32;
  localparam int IA   = 6;
  localparam logic [31:0] IMG_SUM = 32'h40318405;  // 5+7+0x002081B3+0x40110233+0x00000013

  logic            clk_in, rst_n, start, s_valid, s_ready, s_last;
  logic [XLEN-1:0] s_data;
  logic            im_we, rf_we, core_hold, done, error;
  logic [IA-1:0]   im_addr;
  logic [4:0]      rf_addr;
  logic [XLEN-1:0] im_wdata, rf_wdata;
  logic [15:0]     word_count;
  logic [2:0]      fsm_state;

  int checks   = 0;
  int failures = 0;
  logic [40:0] exp_q[$];  // {is_rf, addr[7:0], data[31:0]}
  logic [40:0] got_w, exp_w;
  bit gap_mode    = 0;
  bit prev_strobe = 0;

  prog_loader dut (
    .clk_in(clk_in), .rst_n(rst_n), .start(start), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata), .core_hold(core_hold),
    .done(done), .error(error), .word_count(word_count), .fsm_state(fsm_state)
  );

  // Clock / watchdog
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk_in) begin
    if (rst_n && (im_we || rf_we)) begin
      got_w = {rf_we, rf_we ? {3'b0, rf_addr} : {2'b0, im_addr}, rf_we ? rf_wdata : im_wdata};
      if (gap_mode) check("strobe_gap", 48'(prev_strobe), 48'd0);
      if (im_we && rf_we) check("dual_strobe", 48'd1, 48'd0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_strobe actual=%0h required=none", got_w);
      end else begin
        exp_w = exp_q.pop_front();
        check("write", 48'(got_w), 48'(exp_w));
      end
    end
    prev_strobe = rst_n && (im_we || rf_we);
  end

  // Driver tasks: all start and end at a falling edge.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk_in);
    start = 1'b0;
  endtask

  // kind: 0 = no write expected, 1 = rf write, 2 = im write
  task automatic send(input logic [31:0] d, input logic l, input int kind, input int addr, input int gap);
    int t;
    s_valid = 1'b0;
    repeat (gap) @(negedge clk_in);
    if (kind == 1) exp_q.push_back({1'b1, 8'(addr), d});
    if (kind == 2) exp_q.push_back({1'b0, 8'(addr), d});
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    t = 0;
    while (!s_ready && t < 40) begin
      @(negedge clk_in);
      t++;
    end
    if (!s_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=no_ready required=ready data=%0h", d);
    end else begin
      @(posedge clk_in);
      @(negedge clk_in);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic run_image(input int gap, input logic [31:0] trailer, input bit ok);
    pulse_start();
    check("hdr_ready", 48'(s_ready), 48'd1);
    check("start_clears_done", 48'(done), 48'd0);
    check("start_clears_count", 48'(word_count), 48'd0);
    check("start_hold", 48'(core_hold), 48'd1);
    send(32'h00020003, 1'b0, 0, 0, 0);
    gap_mode = (gap > 0);
    send(32'd5, 1'b0, 1, 1, gap);
    send(32'd7, 1'b0, 1, 2, gap);
    send(32'h002081B3, 1'b0, 2, 0, gap);
    send(32'h40110233, 1'b0, 2, 1, gap);
`ifdef PROG_LOADER_CHECKSUM_EN
    send(32'h00000013, 1'b0, 2, 2, gap);
    gap_mode = 0;
    send(trailer, 1'b1, 0, 0, 0);
`else
    send(32'h00000013, 1'b1, 2, 2, gap);
    gap_mode = 0;
    if (trailer != IMG_SUM) $display("note: trailer unused without checksum");
`endif
    check("ready_drop", 48'(s_ready), 48'd0);
    check("done_not_early", 48'(done), 48'd0);
    check("hold_not_early", 48'(core_hold), 48'd1);
    @(negedge clk_in);
    check("img_done", 48'(done), 48'(ok));
    check("img_error", 48'(error), 48'(!ok));
    check("img_hold", 48'(core_hold), 48'(!ok));
    check("img_count", 48'(word_count), 48'd5);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    repeat (2) @(negedge clk_in);
    check("rst_ready", 48'(s_ready), 48'd0);
    check("rst_strobes", 48'({im_we, rf_we}), 48'd0);
    check("rst_status", 48'({done, error}), 48'd0);
    check("rst_hold", 48'(core_hold), 48'd1);
    check("rst_regs", 48'({im_addr, rf_addr, word_count}), 48'd0);
    check("rst_data", 48'(im_wdata | rf_wdata), 48'd0);
    rst_n = 1'b1;
    @(negedge clk_in);
    check("idle_hold", 48'(core_hold), 48'd1);

    // Nominal image, then the same image with s_valid toggling.
    run_image(0, IMG_SUM, 1'b1);
    run_image(1, IMG_SUM, 1'b1);

    // Oversized header: N = 65.
    pulse_start();
    send(32'h00000041, 1'b0, 0, 0, 0);
    check("ovf_ready", 48'(s_ready), 48'd0);
    check("ovf_error_not_early", 48'(error), 48'd0);
    @(negedge clk_in);
    check("ovf_error", 48'(error), 48'd1);
    check("ovf_hold", 48'(core_hold), 48'd1);
    check("ovf_done", 48'(done), 48'd0);
    check("ovf_count", 48'(word_count), 48'd0);

    // Early s_last on the 2nd of 4 imem words.
    pulse_start();
    send(32'h00000004, 1'b0, 0, 0, 0);
    send(32'h0000000A, 1'b0, 2, 0, 0);
    send(32'h0000000B, 1'b1, 2, 1, 0);
    check("early_last_ready", 48'(s_ready), 48'd0);
    @(negedge clk_in);
    check("early_last_error", 48'(error), 48'd1);
    check("early_last_count", 48'(word_count), 48'd2);
    check("early_last_hold", 48'(core_hold), 48'd1);

`ifdef PROG_LOADER_CHECKSUM_EN
    // Trailer off by one: all data writes still happen.
    run_image(0, IMG_SUM + 32'd1, 1'b0);
`endif

    // Asynchronous reset while IMEM word 2 is being written.
    pulse_start();
    send(32'h00000003, 1'b0, 0, 0, 0);
    send(32'h00000011, 1'b0, 2, 0, 0);
    s_valid = 1'b1;
    s_data  = 32'h00000022;
    @(posedge clk_in);
    #2 rst_n = 1'b0;
    #1;
    s_valid = 1'b0;
    check("arst_im_we", 48'(im_we), 48'd0);
    check("arst_hold", 48'(core_hold), 48'd1);
    check("arst_ready", 48'(s_ready), 48'd0);
    check("arst_count", 48'(word_count), 48'd0);
    check("arst_addr", 48'(im_addr), 48'd0);
    @(negedge clk_in);
    rst_n = 1'b1;
    @(negedge clk_in);
    run_image(0, IMG_SUM, 1'b1);

    repeat (3) @(negedge clk_in);
    check("queue_empty", 48'(exp_q.size()), 48'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
